ber_checker: RTL and testbench
==============================

# ber_checker

Bit-error-rate checker for the convolutional/Viterbi link. Compares the decoder's 16-bit output words against the source words fed to the encoder, which come from the noise generator. It finds the end-to-end pipeline delay automatically, locks onto it, and then counts compared words and bit errors. It sits beside `viterbi_top` on the receive side and closes the loop that the encoder opens.

## Interface
- `WIDTH`, 16, data word width
- `MAX_DELAY`, 64, number of candidate delays searched (0..MAX_DELAY-1); power of two
- `SYNC_WORDS`, 8, consecutive matching words required to lock
- `LOSS_WIN`, 32, words per loss-of-lock window
- `LOSS_THRESH`, 48, bit errors per window above which lock is dropped
- `CNT_W`, 32, counter width

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `clk_enable`  in  1  all state advances only on edges where high
- `tx_data`  in  WIDTH  source word (encoder input)
- `rx_data`  in  WIDTH  decoded word (decoder output)
- `clear`  in  1  synchronous counter clear, acts regardless of `clk_enable`
- `locked`  out  1  delay found and tracking
- `delay`  out  log2(MAX_DELAY)  current candidate/locked delay
- `word_count`  out  CNT_W  words compared while locked
- `bit_err_count`  out  CNT_W  bit errors accumulated while locked
- `word_err`  out  1  one-cycle pulse, previous locked word had ≥1 error

## Operation
- Delay line: `MAX_DELAY-1` registers. On each enabled edge: `hist[0]<=tx_data`, `hist[k]<=hist[k-1]`. It shifts in every state.
- Tap: `tap(0)=tx_data`, `tap(k)=hist[k-1]`. Delay d means rx_data at enabled cycle n equals tx_data at enabled cycle n-d.
- Fill counter saturates at MAX_DELAY and counts enabled cycles since reset. Tap d is valid only when `fill ≥ d`.
- The comparison is combinational: `diff = rx_data ^ tap(delay)`, and `nerr = popcount(diff)` (0..WIDTH).
- FSM states are SEARCH and LOCKED. Reset gives SEARCH, `delay=0`, `match_cnt=0`, window cleared.
- SEARCH, per enabled cycle:
  - Tap invalid: hold `delay`, `match_cnt=0`.
  - `nerr==0`: `match_cnt++`. If `match_cnt==SYNC_WORDS-1`, go to LOCKED and clear the window.
  - `nerr!=0`: `match_cnt=0`, `delay` increments and wraps from MAX_DELAY-1 to 0.
  - Counters hold.
- LOCKED, per enabled cycle:
  - `word_count+=1`, `bit_err_count+=nerr`, `word_err<=(nerr!=0)`.
  - `win_cnt++`, `win_err+=nerr`.
  - On the window's last word (`win_cnt==LOSS_WIN-1`): if `win_err+nerr > LOSS_THRESH`, go to SEARCH with `delay+1` (wrapped) and `match_cnt=0`. Otherwise hold lock. The window clears either way.
  - The current word is counted even if lock drops on it.
- `clear` zeroes both counters. It beats an increment in the same cycle and does not affect FSM, delay, window or `word_err`.
- Counter overflow wraps modulo 2^CNT_W unless `BER_SATURATE_EN` is defined.
- `clk_enable` low: all registers hold, including `word_err`. Only `clear` still acts.

## Timing
- Reset values: `locked=0`, `delay=0`, `word_count=0`, `bit_err_count=0`, `word_err=0`, delay line all zero, fill 0.
- Reset is asynchronous. Assertion mid-LOCKED forces reset values immediately, without waiting for an edge.
- `locked` rises on the edge that samples the SYNC_WORDS-th consecutive matching word. That word is not counted.
- Counting starts with the next enabled word.
- Counters and `word_err` are registered and update on the edge that samples the word (one-cycle latency).
- `locked` falls on the edge that samples the failing window's last word. `delay` advances on the same edge.

## Configuration
- `BER_SATURATE_EN`:
  - Defined: `word_count` and `bit_err_count` saturate at all-ones. A `bit_err_count` addition that would overflow clamps to all-ones.
  - Undefined: both counters wrap modulo 2^CNT_W.

## Test plan
- Distinct nonzero tx words, rx = tx delayed 5 enabled cycles, error-free → `locked=1` by the 14th enabled cycle, `delay=5`, `word_count=0`, `bit_err_count=0`. After 100 more cycles, `word_count=100`.
- Locked at delay 5, flip bit 3 of one rx word → `bit_err_count=1`, `word_err` high exactly one enabled cycle, `locked` stays 1.
- Locked, invert all 16 bits of 4 words in one window (64>48) → `locked=0` at window end, `delay=6`. After sweeping and wrapping, relock at `delay=5`.
- Locked, drop `clk_enable` for 10 cycles while rx keeps the stalled pipeline's value → outputs frozen. On re-enable, lock holds and counting resumes.
- `clear` asserted on the same edge as an error word → both counters 0 afterward. Then `CNT_W=4`: 20 locked words give `word_count=4` (wrap), or 15 with `BER_SATURATE_EN`.
- Assert `reset` asynchronously between edges while locked → `locked`, `delay`, counters and `word_err` read 0 before the next `clk` edge.

Source files
------------

// File: rtl/ber_checker.sv
// ber_checker -- bit-error-rate checker for the convolutional/Viterbi link.
//
// Compares decoded words (rx_data) against the source words (tx_data) fed to
// the encoder. A delay line of past source words is searched for the tap that
// matches the decoder output. Once SYNC_WORDS consecutive words match, the
// checker locks and counts compared words and bit errors. Lock is dropped when
// a LOSS_WIN-word window accumulates more than LOSS_THRESH bit errors, and the
// search resumes at the next delay.
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous, active-high
//   clk_enable     all state advances only on edges where high
//   tx_data        source word (encoder input)
//   rx_data        decoded word (decoder output)
//   clear          synchronous counter clear, acts regardless of clk_enable
//   locked         delay found and tracking
//   delay          current candidate / locked delay
//   word_count     words compared while locked
//   bit_err_count  bit errors accumulated while locked
//   word_err       pulse: previous locked word had at least one bit error
//
// Build option:
//   BER_SATURATE_EN  when defined, word_count and bit_err_count saturate at
//                    all-ones instead of wrapping modulo 2^CNT_W.

module ber_checker #(
    parameter int WIDTH       = 16,
    parameter int MAX_DELAY   = 64,
    parameter int SYNC_WORDS  = 8,
    parameter int LOSS_WIN    = 32,
    parameter int LOSS_THRESH = 48,
    parameter int CNT_W       = 32,
    localparam int DW         = $clog2(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic [WIDTH-1:0] tx_data,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             clear,
    output logic             locked,
    output logic [DW-1:0]    delay,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] bit_err_count,
    output logic             word_err
);

    localparam int FW = DW + 1;                          // fill counter, reaches MAX_DELAY
    localparam int MW = $clog2(SYNC_WORDS) + 1;          // consecutive match counter
    localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int EW = $clog2(LOSS_WIN * WIDTH + 1) + 1; // window error sum incl. current word
    localparam int NW = $clog2(WIDTH + 1);               // popcount of one word
    localparam int AW = ((CNT_W > NW) ? CNT_W : NW) + 1; // overflow-detecting adder

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] hist [MAX_DELAY-1];
    logic [WIDTH-1:0] taps [MAX_DELAY];
    logic [FW-1:0]    fill;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic [WW-1:0]    win_cnt, win_cnt_nxt;
    logic [EW-1:0]    win_err, win_err_nxt, win_sum;
    logic [DW-1:0]    delay_nxt;
    logic [WIDTH-1:0] diff;
    logic [NW-1:0]    nerr;
    logic             tap_valid;

    function automatic logic [NW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [NW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + NW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] add_err(input logic [CNT_W-1:0] a,
                                                 input logic [NW-1:0]    b);
`ifdef BER_SATURATE_EN
        logic [AW-1:0] s;
        s = AW'(a) + AW'(b);
        return (|s[AW-1:CNT_W]) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
`else
        // Truncating b first is harmless: the sum is taken modulo 2^CNT_W.
        return a + CNT_W'(b);
`endif
    endfunction

    function automatic logic [CNT_W-1:0] inc_word(input logic [CNT_W-1:0] a);
`ifdef BER_SATURATE_EN
        return (&a) ? a : a + 1'b1;
`else
        return a + 1'b1;
`endif
    endfunction

    // Tap 0 is the live source word; tap k is the word from k enabled cycles ago.
    always_comb begin
        taps[0] = tx_data;
        for (int k = 1; k < MAX_DELAY; k++) begin
            taps[k] = hist[k-1];
        end
    end

    assign diff      = rx_data ^ taps[delay];
    assign nerr      = popcount(diff);
    assign tap_valid = (fill >= {1'b0, delay});
    assign win_sum   = win_err + EW'(nerr);
    assign locked    = (state == LOCK);

    // Delay line and fill counter shift in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAX_DELAY - 1; k++) begin
                hist[k] <= '0;
            end
            fill <= '0;
        end else if (clk_enable) begin
            hist[0] <= tx_data;
            for (int k = 1; k < MAX_DELAY - 1; k++) begin
                hist[k] <= hist[k-1];
            end
            if (fill != FW'(MAX_DELAY)) begin
                fill <= fill + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        delay_nxt   = delay;
        match_nxt   = match_cnt;
        win_cnt_nxt = win_cnt;
        win_err_nxt = win_err;
        case (state)
            SEARCH: begin
                if (!tap_valid) begin
                    match_nxt = '0;
                end else if (nerr == '0) begin
                    if (match_cnt == MW'(SYNC_WORDS - 1)) begin
                        state_nxt   = LOCK;
                        match_nxt   = '0;
                        win_cnt_nxt = '0;
                        win_err_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + 1'b1;
                    end
                end else begin
                    match_nxt = '0;
                    delay_nxt = delay + 1'b1;   // wraps since MAX_DELAY is a power of two
                end
            end
            LOCK: begin
                if (win_cnt == WW'(LOSS_WIN - 1)) begin
                    win_cnt_nxt = '0;
                    win_err_nxt = '0;
                    if (win_sum > EW'(LOSS_THRESH)) begin
                        state_nxt = SEARCH;
                        delay_nxt = delay + 1'b1;
                        match_nxt = '0;
                    end
                end else begin
                    win_cnt_nxt = win_cnt + 1'b1;
                    win_err_nxt = win_sum;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            delay     <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else if (clk_enable) begin
            state     <= state_nxt;
            delay     <= delay_nxt;
            match_cnt <= match_nxt;
            win_cnt   <= win_cnt_nxt;
            win_err   <= win_err_nxt;
        end
    end

    // Counters: clear wins over an increment and ignores clk_enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count    <= '0;
            bit_err_count <= '0;
        end else if (clear) begin
            word_count    <= '0;
            bit_err_count <= '0;
        end else if (clk_enable && state == LOCK) begin
            word_count    <= inc_word(word_count);
            bit_err_count <= add_err(bit_err_count, nerr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_err <= 1'b0;
        end else if (clk_enable) begin
            word_err <= (state == LOCK) && (nerr != '0);
        end
    end

endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker -- directed bench for ber_checker.
// Main instance uses default parameters; a second instance with CNT_W=4
// exercises counter wrap (or saturation when BER_SATURATE_EN is defined).

module tb_ber_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [15:0] tx_data, rx_data;
    logic        clear;
    logic        locked;
    logic [5:0]  delay;
    logic [31:0] word_count, bit_err_count;
    logic        word_err;

    logic        en4;
    logic [15:0] tx4, rx4;
    logic        locked4;
    logic [5:0]  delay4;
    logic [3:0]  wc4, bec4;
    logic        werr4;

    int checks = 0;
    int errors = 0;
    int n  = 0;
    int n4 = 0;

    always #5 clk = ~clk;

    ber_checker dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .tx_data(tx_data), .rx_data(rx_data), .clear(clear),
        .locked(locked), .delay(delay), .word_count(word_count),
        .bit_err_count(bit_err_count), .word_err(word_err)
    );

    ber_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .clk_enable(en4),
        .tx_data(tx4), .rx_data(rx4), .clear(1'b0),
        .locked(locked4), .delay(delay4), .word_count(wc4),
        .bit_err_count(bec4), .word_err(werr4)
    );

    function automatic logic [15:0] src(input int i);
        return 16'(i + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One enabled cycle on the main instance; rx is tx delayed 5 words.
    task automatic step(input logic [15:0] mask, input logic clr);
        tx_data    = src(n);
        rx_data    = ((n >= 5) ? src(n - 5) : 16'h0000) ^ mask;
        clk_enable = 1'b1;
        clear      = clr;
        @(posedge clk);
        #1;
        clear = 1'b0;
        n++;
    endtask

    task automatic step4(input logic [15:0] mask);
        tx4 = src(n4);
        rx4 = ((n4 >= 5) ? src(n4 - 5) : 16'h0000) ^ mask;
        en4 = 1'b1;
        @(posedge clk);
        #1;
        n4++;
    endtask

    initial begin
        int steps;
        reset = 1'b1; clk_enable = 1'b0; clear = 1'b0;
        tx_data = '0; rx_data = '0; en4 = 1'b0; tx4 = '0; rx4 = '0;
        #12;
        reset = 1'b0;

        check("rst_locked", 32'(locked), 32'd0);
        check("rst_delay", 32'(delay), 32'd0);
        check("rst_wc", word_count, 32'd0);
        check("rst_bec", bit_err_count, 32'd0);
        check("rst_werr", 32'(word_err), 32'd0);

        // Acquisition at delay 5
        steps = 0;
        while (!locked && steps < 14) begin
            step(16'h0000, 1'b0);
            steps++;
        end
        check("lock_time", 32'(steps), 32'd13);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_delay", 32'(delay), 32'd5);
        check("lock_wc", word_count, 32'd0);
        check("lock_bec", bit_err_count, 32'd0);
        repeat (100) step(16'h0000, 1'b0);
        check("wc_100", word_count, 32'd100);
        check("bec_100", bit_err_count, 32'd0);

        // Single bit error
        step(16'h0008, 1'b0);
        check("bit3_bec", bit_err_count, 32'd1);
        check("bit3_werr", 32'(word_err), 32'd1);
        check("bit3_locked", 32'(locked), 32'd1);
        step(16'h0000, 1'b0);
        check("bit3_werr_off", 32'(word_err), 32'd0);
        check("bit3_wc", word_count, 32'd102);

        // 64 errors in one window: words 102..105 inverted, window ends at word 127
        repeat (4) step(16'hFFFF, 1'b0);
        repeat (21) step(16'h0000, 1'b0);
        check("loss_hold", 32'(locked), 32'd1);
        step(16'h0000, 1'b0);
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_delay", 32'(delay), 32'd6);
        check("loss_wc", word_count, 32'd128);
        check("loss_bec", bit_err_count, 32'd65);

        // Sweep through wrap back to delay 5
        steps = 0;
        while (!locked && steps < 200) begin
            step(16'h0000, 1'b0);
            steps++;
        end
        check("relock_steps", 32'(steps), 32'd71);
        check("relock_delay", 32'(delay), 32'd5);
        check("relock_wc", word_count, 32'd128);

        // Stall with word_err high
        step(16'h0001, 1'b0);
        check("pre_stall_werr", 32'(word_err), 32'd1);
        clk_enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_mid_wc", word_count, 32'd129);
        repeat (5) @(posedge clk);
        #1;
        check("stall_wc", word_count, 32'd129);
        check("stall_bec", bit_err_count, 32'd66);
        check("stall_werr", 32'(word_err), 32'd1);
        check("stall_locked", 32'(locked), 32'd1);
        check("stall_delay", 32'(delay), 32'd5);
        step(16'h0000, 1'b0);
        check("resume_wc", word_count, 32'd130);
        check("resume_werr", 32'(word_err), 32'd0);
        check("resume_locked", 32'(locked), 32'd1);

        // Clear on the same edge as an error word
        step(16'hFFFF, 1'b1);
        check("clr_wc", word_count, 32'd0);
        check("clr_bec", bit_err_count, 32'd0);
        check("clr_werr", 32'(word_err), 32'd1);
        check("clr_locked", 32'(locked), 32'd1);
        step(16'h0000, 1'b0);
        check("post_clr_wc", word_count, 32'd1);
        check("post_clr_bec", bit_err_count, 32'd0);

        // 4-bit counters: 20 locked words, first fully inverted
        clk_enable = 1'b0;
        repeat (13) step4(16'h0000);
        check("c4_locked", 32'(locked4), 32'd1);
        step4(16'hFFFF);
        repeat (19) step4(16'h0000);
`ifdef BER_SATURATE_EN
        check("c4_wc", 32'(wc4), 32'd15);
        check("c4_bec", 32'(bec4), 32'd15);
`else
        check("c4_wc", 32'(wc4), 32'd4);
        check("c4_bec", 32'(bec4), 32'd0);
`endif
        en4 = 1'b0;

        // Asynchronous reset while locked
        step(16'h0002, 1'b0);
        check("prerst_werr", 32'(word_err), 32'd1);
        check("prerst_wc", word_count, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_delay", 32'(delay), 32'd0);
        check("arst_wc", word_count, 32'd0);
        check("arst_bec", bit_err_count, 32'd0);
        check("arst_werr", 32'(word_err), 32'd0);
        check("arst_locked4", 32'(locked4), 32'd0);
        #3;
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
